urng_arbiter: RTL and testbench

Round-robin controller that shares one step-enabled Tausworthe uniform generator (two 32-bit words per step, U1/U2) among NREQ consumers in the Gaussian noise datapath, e.g. Box-Muller units and a test tap. After reset it discards WARMUP generator steps so the first served samples are decorrelated from the fixed seeds. It then advances the generator exactly once per granted request and holds the resulting U1/U2 pair until the granted requester acknowledges it. No sample is ever delivered twice or to two requesters.

---
 rtl/urng_arbiter_if.sv | 33 +++
 rtl/urng_arbiter.sv | 168 ++++++++++++++++
 tb/tb_urng_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/urng_arbiter_if.sv
// Purpose: bundles the requester-side handshake and the generator-side signals of urng_arbiter.
// Latency: none; this is wiring only.
// Backpressure: none here; requesters hold a delivery by keeping req high without ack.
//
// Ports (the modports are seen from urng_arbiter):
//   master : req, ack, gen_u1, gen_u2 in; gen_en, u1, u2, valid, gnt_id, ready, served out
//   slave  : the mirror of master, used by the consumers and the generator
interface urng_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            gen_en;
  logic [31:0]     gen_u1;
  logic [31:0]     gen_u2;
  logic [31:0]     u1;
  logic [31:0]     u2;
  logic [NREQ-1:0] valid;
  logic [IDW-1:0]  gnt_id;
  logic            ready;
  logic [31:0]     served;

  modport master (
    input  req, ack, gen_u1, gen_u2,
    output gen_en, u1, u2, valid, gnt_id, ready, served
  );

  modport slave (
    output req, ack, gen_u1, gen_u2,
    input  gen_en, u1, u2, valid, gnt_id, ready, served
  );
endinterface

// File: rtl/urng_arbiter.sv
// Purpose: round-robin sharing of one step-enabled U1/U2 uniform generator among NREQ consumers.
// Latency: req sampled in IDLE at edge n -> generator steps at n+1 -> valid[i] high after n+2.
// Backpressure: the sample is held in HOLD until ack[gnt_id], or dropped if req[gnt_id] falls.
//
// Ports:
//   clk, rst : single rising-edge clock; synchronous active-high reset
//   bus      : urng_arbiter_if.master carrying req/ack, gen_en/gen_u1/gen_u2,
//              u1/u2/valid/gnt_id, ready and the served counter
// After reset the generator is stepped WARMUP times with nothing delivered, so the
// first served words are decorrelated from the generator's fixed seeds.
module urng_arbiter #(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int WARMUP = 16
) (
  input  logic           clk,
  input  logic           rst,
  urng_arbiter_if.master bus
);

  localparam logic [15:0]   WARM_LIM = 16'(WARMUP);
  localparam logic [IDW:0]  NREQ_W   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  typedef enum logic [2:0] {
    ST_WARM,
    ST_IDLE,
    ST_STEP,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     warm_cnt_q, warm_cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_q, gnt_d;
  logic            gen_en_q, gen_en_d;
  logic            ready_q, ready_d;
  logic [31:0]     u1_q, u1_d;
  logic [31:0]     u2_q, u2_d;
  logic [31:0]     served_q, served_d;
  logic [NREQ-1:0] valid_q, valid_d;

  // Round-robin pick: first requester at or after ptr, wrapping modulo NREQ.
  // cand is one bit wider than an index so ptr+k never overflows before the wrap.
  logic           pick_found;
  logic [IDW-1:0] pick_id;
  logic [IDW:0]   cand;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = ptr_q;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!pick_found && bus.req[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick_id    = cand[IDW-1:0];
      end
    end
  end

  // Pointer moves past the last grant whether it was acked or abandoned.
  logic [IDW-1:0] ptr_after_gnt;
  assign ptr_after_gnt = (gnt_q == LAST_ID) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    warm_cnt_d = warm_cnt_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gen_en_d   = 1'b0;
    ready_d    = ready_q;
    u1_d       = u1_q;
    u2_d       = u2_q;
    served_d   = served_q;
    valid_d    = valid_q;

    unique case (state_q)
      ST_WARM: begin
        ready_d = 1'b0;
        if (warm_cnt_q == WARM_LIM) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          gen_en_d   = 1'b1;
          warm_cnt_d = warm_cnt_q + 16'd1;
        end
      end

      ST_IDLE: begin
        if (pick_found) begin
          gnt_d    = pick_id;
          gen_en_d = 1'b1;
          state_d  = ST_STEP;
        end
      end

      // The generator advances on this edge; its new words are visible in WAIT.
      ST_STEP: begin
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        u1_d    = bus.gen_u1;
        u2_d    = bus.gen_u2;
        valid_d = NREQ'(1) << gnt_q;
        state_d = ST_HOLD;
      end

      // ack wins over a simultaneous req drop; foreign ack bits are ignored.
      ST_HOLD: begin
        if (bus.ack[gnt_q]) begin
          valid_d  = '0;
          served_d = served_q + 32'd1;
          ptr_d    = ptr_after_gnt;
          state_d  = ST_IDLE;
        end else if (!bus.req[gnt_q]) begin
          valid_d = '0;
          ptr_d   = ptr_after_gnt;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_WARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WARM;
      warm_cnt_q <= '0;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gen_en_q   <= 1'b0;
      ready_q    <= 1'b0;
      u1_q       <= '0;
      u2_q       <= '0;
      served_q   <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      warm_cnt_q <= warm_cnt_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gen_en_q   <= gen_en_d;
      ready_q    <= ready_d;
      u1_q       <= u1_d;
      u2_q       <= u2_d;
      served_q   <= served_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.gen_en = gen_en_q;
  assign bus.ready  = ready_q;
  assign bus.u1     = u1_q;
  assign bus.u2     = u2_q;
  assign bus.valid  = valid_q;
  assign bus.gnt_id = gnt_q;
  assign bus.served = served_q;

endmodule

// File: tb/tb_urng_arbiter.sv
// Purpose: directed scoreboard bench for urng_arbiter with a counting generator stand-in.
// Latency: expected deliveries are queued ahead of time and popped when valid rises.
// Backpressure: the bench plays requesters that ack, hold, abandon and send foreign acks.
module tb_urng_arbiter;
  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int WARMUP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  urng_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  urng_arbiter #(.NREQ(NREQ), .IDW(IDW), .WARMUP(WARMUP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Generator stand-in: after k steps since reset it shows U1 = 0x13570000+k, U2 = 0xC0DE0000+k.
  logic [31:0] gstep = '0;
  always @(posedge clk) begin
    if (rst) gstep <= '0;
    else if (bus.gen_en) gstep <= gstep + 32'd1;
  end
  assign bus.gen_u1 = 32'h1357_0000 + gstep;
  assign bus.gen_u2 = 32'hC0DE_0000 + gstep;

  typedef struct {
    int id;
    int step;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic expect_dlv(input int id, input int step);
    exp_t e;
    e.id   = id;
    e.step = step;
    q.push_back(e);
  endtask

  // Monitor: every rising of valid is one delivery and must match the head of the queue.
  logic [NREQ-1:0] prev_valid = '0;
  always @(negedge clk) begin
    if (bus.valid != '0 && prev_valid == '0) begin
      if (q.size() == 0) begin
        chk("unexpected_delivery", 64'(bus.valid), 64'd0);
      end else begin
        exp_t e;
        logic [NREQ-1:0] onehot;
        e = q.pop_front();
        onehot = NREQ'(1) << e.id;
        chk("dlv_valid",  64'(bus.valid),  64'(onehot));
        chk("dlv_gnt_id", 64'(bus.gnt_id), 64'(e.id));
        chk("dlv_u1",     64'(bus.u1),     64'(32'h1357_0000 + 32'(e.step)));
        chk("dlv_u2",     64'(bus.u2),     64'(32'hC0DE_0000 + 32'(e.step)));
      end
    end
    prev_valid <= bus.valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gen_en"}, 64'(bus.gen_en), 64'd0);
    chk({tag, "_valid"},  64'(bus.valid),  64'd0);
    chk({tag, "_gnt_id"}, 64'(bus.gnt_id), 64'd0);
    chk({tag, "_u1"},     64'(bus.u1),     64'd0);
    chk({tag, "_u2"},     64'(bus.u2),     64'd0);
    chk({tag, "_served"}, 64'(bus.served), 64'd0);
    chk({tag, "_ready"},  64'(bus.ready),  64'd0);
  endtask

  // Releases reset at a falling edge; the next rising edge is release edge 0.
  // gen_en must be seen high after edges 0..15 and ready first after edge 16.
  task automatic do_warm(input string tag);
    int n;
    int g;
    n = 0;
    g = 0;
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.gen_en) g++;
      if (bus.ready) break;
      n++;
    end
    chk({tag, "_ready_edge"}, 64'(n), 64'd16);
    chk({tag, "_warm_steps"}, 64'(g), 64'd16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.req = '0;
    bus.ack = '0;

    // Reset and warm-up with req=0001 held throughout.
    rst     = 1'b1;
    bus.req = 4'b0001;
    cyc(2);
    chk_reset("rst0");
    expect_dlv(0, 17);
    do_warm("warm0");
    cyc(1);
    chk("grant_gen_en", 64'(bus.gen_en), 64'd1);
    chk("grant_gnt_id", 64'(bus.gnt_id), 64'd0);
    cyc(1);
    chk("step_gen_en", 64'(bus.gen_en), 64'd0);
    chk("step_valid",  64'(bus.valid),  64'd0);
    cyc(1);
    chk("first_valid", 64'(bus.valid), 64'b0001);

    // Single requester acking at the first chance: one delivery every 4 cycles.
    expect_dlv(0, 18);
    expect_dlv(0, 19);
    expect_dlv(0, 20);
    bus.ack = 4'b0001;
    g = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (bus.gen_en) g++;
    end
    chk("single_gen_pulses", 64'(g), 64'd3);
    chk("single_served",     64'(bus.served), 64'd4);
    chk("single_valid_off",  64'(bus.valid),  64'd0);

    // Reset during WAIT: the pending sample must never appear.
    bus.ack = 4'b0000;
    bus.req = 4'b0001;
    cyc(1);
    chk("t6_grant_gen_en", 64'(bus.gen_en), 64'd1);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    chk_reset("rst_wait");
    expect_dlv(0, 17);
    do_warm("warm1");
    cyc(3);
    chk("t6_hold_valid", 64'(bus.valid), 64'b0001);

    // Reset during HOLD.
    rst = 1'b1;
    cyc(1);
    chk_reset("rst_hold");

    // All four requesting, every grant acked at once: ids 0,1,2,3,0.
    bus.req = 4'b1111;
    bus.ack = 4'b1111;
    expect_dlv(0, 17);
    expect_dlv(1, 18);
    expect_dlv(2, 19);
    expect_dlv(3, 20);
    expect_dlv(0, 21);
    do_warm("warm2");
    cyc(20);
    chk("rr_served", 64'(bus.served), 64'd5);
    bus.req = 4'b0000;
    bus.ack = 4'b0000;

    // Grant to id 2, abandoned in HOLD; next grant must skip id 0 and go to id 3.
    bus.req = 4'b0100;
    expect_dlv(2, 22);
    cyc(1);
    chk("t4_gnt_id", 64'(bus.gnt_id), 64'd2);
    cyc(2);
    chk("t4_hold_valid", 64'(bus.valid), 64'b0100);
    bus.req = 4'b1001;
    cyc(1);
    chk("abandon_valid",  64'(bus.valid),  64'd0);
    chk("abandon_served", 64'(bus.served), 64'd5);
    expect_dlv(3, 23);
    cyc(1);
    chk("rr_after_abandon", 64'(bus.gnt_id), 64'd3);
    cyc(2);
    chk("id3_valid", 64'(bus.valid), 64'b1000);

    // ack and req drop together counts as ack; then id 1 with a foreign ack.
    bus.ack = 4'b1000;
    bus.req = 4'b0010;
    expect_dlv(1, 24);
    cyc(1);
    chk("ack_drop_served", 64'(bus.served), 64'd6);
    chk("ack_drop_valid",  64'(bus.valid),  64'd0);
    bus.ack = 4'b0000;
    cyc(1);
    chk("id1_gnt_id", 64'(bus.gnt_id), 64'd1);
    cyc(2);
    chk("id1_valid", 64'(bus.valid), 64'b0010);
    bus.ack = 4'b0100;
    cyc(2);
    chk("foreign_ack_valid",  64'(bus.valid),  64'b0010);
    chk("foreign_ack_served", 64'(bus.served), 64'd6);
    bus.ack = 4'b0010;
    cyc(1);
    chk("own_ack_valid",  64'(bus.valid),  64'd0);
    chk("own_ack_served", 64'(bus.served), 64'd7);
    bus.ack = 4'b0000;
    bus.req = 4'b0000;

    // Idle with no requests: the generator must not be stepped.
    g = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gen_en) g++;
    end
    chk("idle_no_steps", 64'(g), 64'd0);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
